// File: rtl/spi_endpoint_arbiter_if.sv
// Message-side bundle between the SPI minion adapter, the endpoint arbiter and its endpoints.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface spi_endpoint_arbiter_if #(
   parameter int nbits      = 32,
   parameter int num_ports  = 3,
   parameter int addr_nbits = 2
);
   localparam int W = nbits - 2;
   localparam int P = W - addr_nbits;

   logic                   in_val;
   logic                   in_rdy;
   logic [W-1:0]           in_msg;
   logic                   out_val;
   logic                   out_rdy;
   logic [W-1:0]           out_msg;
   logic [num_ports-1:0]   ep_req_val;
   logic [num_ports-1:0]   ep_req_rdy;
   logic [P-1:0]           ep_req_msg;
   logic [num_ports-1:0]   ep_resp_val;
   logic [num_ports-1:0]   ep_resp_rdy;
   logic [num_ports*P-1:0] ep_resp_msg;

   modport slave (
      input  in_val, in_msg, out_rdy, ep_req_rdy, ep_resp_val, ep_resp_msg,
      output in_rdy, out_val, out_msg, ep_req_val, ep_req_msg, ep_resp_rdy
   );

   modport master (
      output in_val, in_msg, out_rdy, ep_req_rdy, ep_resp_val, ep_resp_msg,
      input  in_rdy, out_val, out_msg, ep_req_val, ep_req_msg, ep_resp_rdy
   );
endinterface

// File: rtl/spi_endpoint_arbiter.sv
// Routes adapter messages to num_ports endpoints by address and round-robin merges their
// responses back, each path through a 1-entry buffer; bad addresses return an error response.
module spi_endpoint_arbiter #(
   parameter int nbits      = 32,
   parameter int num_ports  = 3,
   parameter int addr_nbits = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   spi_endpoint_arbiter_if.slave bus,
   output logic [7:0]            err_count
);
   localparam int W = nbits - 2;
   localparam int P = W - addr_nbits;
   localparam logic [addr_nbits-1:0] ErrPort = addr_nbits'(num_ports);

   logic                  req_full_q;
   logic [addr_nbits-1:0] req_port_q;
   logic [P-1:0]          req_payload_q;
   logic                  resp_full_q;
   logic [W-1:0]          resp_msg_q;
   logic                  err_pend_q;
   logic [addr_nbits-1:0] rr_ptr_q;
   logic [7:0]            err_count_q;

   logic [addr_nbits-1:0] in_addr;
   logic                  in_addr_ok, in_acc, req_drain;
   logic [num_ports-1:0]  ep_req_val_c, ep_resp_rdy_c;
   logic                  out_val_c, out_fire, slot_free, err_grant, ep_grant;
   logic                  hit_hi, hit_lo;
   logic [addr_nbits-1:0] idx_hi, idx_lo, grant_idx, rr_next;
   logic [P-1:0]          pay_hi, pay_lo, grant_pay;

   // Request path
   assign in_addr    = bus.in_msg[W-1 -: addr_nbits];
   assign in_addr_ok = int'(in_addr) < num_ports;
   assign bus.in_rdy = !reset && !req_full_q && !err_pend_q;
   assign in_acc     = bus.in_val && bus.in_rdy;

   always_comb begin
      ep_req_val_c = '0;
      for (int i = 0; i < num_ports; i++) begin
         ep_req_val_c[i] = !reset && req_full_q && (req_port_q == addr_nbits'(i));
      end
   end

   assign bus.ep_req_val = ep_req_val_c;
   assign bus.ep_req_msg = req_payload_q;
   assign req_drain      = |(ep_req_val_c & bus.ep_req_rdy);

   // Two-pass round-robin: lowest valid port at or above rr_ptr, else lowest valid overall.
   always_comb begin
      hit_hi = 1'b0;
      hit_lo = 1'b0;
      idx_hi = '0;
      idx_lo = '0;
      pay_hi = '0;
      pay_lo = '0;
      for (int i = num_ports - 1; i >= 0; i--) begin
         if (bus.ep_resp_val[i]) begin
            hit_lo = 1'b1;
            idx_lo = addr_nbits'(i);
            pay_lo = bus.ep_resp_msg[i*P +: P];
            if (i >= int'(rr_ptr_q)) begin
               hit_hi = 1'b1;
               idx_hi = addr_nbits'(i);
               pay_hi = bus.ep_resp_msg[i*P +: P];
            end
         end
      end
   end

   assign grant_idx = hit_hi ? idx_hi : idx_lo;
   assign grant_pay = hit_hi ? pay_hi : pay_lo;
   assign rr_next   = (int'(grant_idx) == num_ports - 1) ? '0 : grant_idx + addr_nbits'(1);

   assign out_val_c = !reset && resp_full_q;
   assign out_fire  = out_val_c && bus.out_rdy;
   assign slot_free = !resp_full_q || out_fire;
   assign err_grant = !reset && slot_free && err_pend_q;
   assign ep_grant  = !reset && slot_free && !err_pend_q && (hit_hi || hit_lo);

   always_comb begin
      ep_resp_rdy_c = '0;
      for (int i = 0; i < num_ports; i++) begin
         ep_resp_rdy_c[i] = ep_grant && (grant_idx == addr_nbits'(i));
      end
   end

   assign bus.ep_resp_rdy = ep_resp_rdy_c;
   assign bus.out_val     = out_val_c;
   assign bus.out_msg     = resp_msg_q;
   assign err_count       = err_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         req_full_q    <= 1'b0;
         req_port_q    <= '0;
         req_payload_q <= '0;
         resp_full_q   <= 1'b0;
         resp_msg_q    <= '0;
         err_pend_q    <= 1'b0;
         rr_ptr_q      <= '0;
         err_count_q   <= '0;
      end else begin
         if (req_drain) req_full_q <= 1'b0;
         if (in_acc) begin
            if (in_addr_ok) begin
               req_full_q    <= 1'b1;
               req_port_q    <= in_addr;
               req_payload_q <= bus.in_msg[P-1:0];
            end else begin
               err_pend_q <= 1'b1;
               if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            end
         end
         // accept and error grant are mutually exclusive through err_pend_q
         if (out_fire) resp_full_q <= 1'b0;
         if (err_grant) begin
            resp_full_q <= 1'b1;
            resp_msg_q  <= {ErrPort, {P{1'b1}}};
            err_pend_q  <= 1'b0;
         end else if (ep_grant) begin
            resp_full_q <= 1'b1;
            resp_msg_q  <= {grant_idx, grant_pay};
            rr_ptr_q    <= rr_next;
         end
      end
   end
endmodule

// File: tb/tb_spi_endpoint_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_spi_endpoint_arbiter;
   localparam int NBITS = 32;
   localparam int NP    = 3;
   localparam int AW    = 2;
   localparam int W     = NBITS - 2;
   localparam int P     = W - AW;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] err_count;
   int         tests = 0;
   int         fails = 0;

   spi_endpoint_arbiter_if #(.nbits(NBITS), .num_ports(NP), .addr_nbits(AW)) bus ();

   spi_endpoint_arbiter #(.nbits(NBITS), .num_ports(NP), .addr_nbits(AW)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.in_val      = 1'b0;
      bus.in_msg      = '0;
      bus.out_rdy     = 1'b0;
      bus.ep_req_rdy  = '0;
      bus.ep_resp_val = '0;
      bus.ep_resp_msg = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [W-1:0] mk(int a, logic [P-1:0] p);
      return {AW'(a), p};
   endfunction

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      bus.in_val      = 1'b1;
      bus.in_msg      = mk(0, 28'h1);
      bus.ep_resp_val = 3'b111;
      @(negedge clk);
      tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL reset_in_rdy_during: got %b want 0", bus.in_rdy); end
      tests++; if (bus.ep_resp_rdy !== 3'b000) begin fails++; $display("FAIL reset_resp_rdy_during: got %b want 000", bus.ep_resp_rdy); end
      tick();
      reset = 1'b0;
      bus.in_val = 1'b0;
      bus.ep_resp_val = '0;
      @(negedge clk);
      tests++; if (bus.out_val !== 1'b0) begin fails++; $display("FAIL reset_out_val: got %b want 0", bus.out_val); end
      tests++; if (bus.ep_req_val !== 3'b000) begin fails++; $display("FAIL reset_ep_req_val: got %b want 000", bus.ep_req_val); end
      tests++; if (bus.ep_resp_rdy !== 3'b000) begin fails++; $display("FAIL reset_ep_resp_rdy: got %b want 000", bus.ep_resp_rdy); end
      tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy: got %b want 1", bus.in_rdy); end
      tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      tick();
      @(negedge clk);
      tests++; if (bus.ep_req_val !== 3'b000) begin fails++; $display("FAIL reset_no_accept: got %b want 000", bus.ep_req_val); end
      tick();
   endtask

   task automatic test_routing();
      do_reset();
      bus.in_val     = 1'b1;
      bus.in_msg     = mk(1, 28'h0ABCDEF);
      bus.ep_req_rdy = 3'b111;
      @(negedge clk);
      tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL route_in_rdy: got %b want 1", bus.in_rdy); end
      tick();
      bus.in_val = 1'b0;
      @(negedge clk);
      tests++; if (bus.ep_req_val !== 3'b010) begin fails++; $display("FAIL route_val: got %b want 010", bus.ep_req_val); end
      tests++; if (bus.ep_req_msg !== 28'h0ABCDEF) begin fails++; $display("FAIL route_msg: got %h want 0abcdef", bus.ep_req_msg); end
      tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL route_in_rdy_full: got %b want 0", bus.in_rdy); end
      tick();
      @(negedge clk);
      tests++; if (bus.ep_req_val !== 3'b000) begin fails++; $display("FAIL route_val_clear: got %b want 000", bus.ep_req_val); end
      tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL route_in_rdy_again: got %b want 1", bus.in_rdy); end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.in_val     = 1'b1;
      bus.in_msg     = mk(0, 28'h1234567);
      bus.ep_req_rdy = 3'b110;
      tick();
      bus.in_val = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests++; if (bus.ep_req_val !== 3'b001) begin fails++; $display("FAIL bp_val c%0d: got %b want 001", c, bus.ep_req_val); end
         tests++; if (bus.ep_req_msg !== 28'h1234567) begin fails++; $display("FAIL bp_msg c%0d: got %h want 1234567", c, bus.ep_req_msg); end
         tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL bp_in_rdy c%0d: got %b want 0", c, bus.in_rdy); end
         tick();
      end
      bus.ep_req_rdy = 3'b111;
      @(negedge clk);
      tests++; if (bus.ep_req_val !== 3'b001) begin fails++; $display("FAIL bp_release_val: got %b want 001", bus.ep_req_val); end
      tick();
      @(negedge clk);
      tests++; if (bus.ep_req_val !== 3'b000) begin fails++; $display("FAIL bp_after_val: got %b want 000", bus.ep_req_val); end
      tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL bp_after_in_rdy: got %b want 1", bus.in_rdy); end
      tick();
   endtask

   task automatic test_fairness();
      do_reset();
      bus.ep_resp_msg = {28'd3, 28'd2, 28'd1};
      bus.ep_resp_val = 3'b111;
      bus.out_rdy     = 1'b1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         tests++; if (bus.ep_resp_rdy !== NP'(1 << (k % NP))) begin fails++; $display("FAIL fair_grant k%0d: got %b want %b", k, bus.ep_resp_rdy, NP'(1 << (k % NP))); end
         if (k > 0) begin
            tests++; if (bus.out_val !== 1'b1 || bus.out_msg !== mk((k-1) % NP, P'((k-1) % NP + 1))) begin
               fails++; $display("FAIL fair_msg k%0d: got val=%b msg=%h want msg=%h", k, bus.out_val, bus.out_msg, mk((k-1) % NP, P'((k-1) % NP + 1)));
            end
         end
         tick();
      end
      bus.ep_resp_val = '0;
      @(negedge clk);
      tests++; if (bus.out_msg !== mk(0, 28'd1) || bus.ep_resp_rdy !== 3'b000) begin fails++; $display("FAIL fair_last: got msg=%h rdy=%b want msg=%h rdy=000", bus.out_msg, bus.ep_resp_rdy, mk(0, 28'd1)); end
      tick();
      @(negedge clk);
      tests++; if (bus.out_val !== 1'b0) begin fails++; $display("FAIL fair_drained: got %b want 0", bus.out_val); end
      tick();
   endtask

   task automatic test_invalid_addr();
      do_reset();
      bus.in_val  = 1'b1;
      bus.in_msg  = mk(3, 28'h1);
      bus.out_rdy = 1'b1;
      tick();
      bus.in_val = 1'b0;
      bus.ep_resp_msg = {28'h0, 28'h55, 28'h0};
      bus.ep_resp_val = 3'b010;
      @(negedge clk);
      tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL inv_err_count: got %0d want 1", err_count); end
      tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL inv_in_rdy: got %b want 0", bus.in_rdy); end
      tests++; if (bus.ep_resp_rdy !== 3'b000) begin fails++; $display("FAIL inv_priority: got %b want 000", bus.ep_resp_rdy); end
      tick();
      @(negedge clk);
      tests++; if (bus.out_val !== 1'b1 || bus.out_msg !== mk(3, 28'hFFFFFFF)) begin fails++; $display("FAIL inv_err_msg: got val=%b msg=%h want %h", bus.out_val, bus.out_msg, mk(3, 28'hFFFFFFF)); end
      tests++; if (bus.ep_resp_rdy !== 3'b010) begin fails++; $display("FAIL inv_next_grant: got %b want 010", bus.ep_resp_rdy); end
      tests++; if (bus.in_rdy !== 1'b1) begin fails++; $display("FAIL inv_in_rdy_back: got %b want 1", bus.in_rdy); end
      tick();
      bus.ep_resp_val = '0;
      @(negedge clk);
      tests++; if (bus.out_msg !== mk(1, 28'h55)) begin fails++; $display("FAIL inv_port1_msg: got %h want %h", bus.out_msg, mk(1, 28'h55)); end
      tick();
   endtask

   task automatic test_err_saturation();
      int sent;
      bit prev_acc;
      sent = 0;
      prev_acc = 1'b0;
      do_reset();
      bus.out_rdy = 1'b1;
      bus.in_msg  = mk(3, 28'h1);
      for (int cyc = 0; cyc < 1000 && sent < 300; cyc++) begin
         bus.in_val = 1'b1;
         @(negedge clk);
         tests++; if (err_count !== 8'((sent > 255) ? 255 : sent)) begin fails++; $display("FAIL sat_count cyc%0d: got %0d want %0d", cyc, err_count, (sent > 255) ? 255 : sent); end
         if (prev_acc) begin
            tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL sat_stall cyc%0d: got in_rdy=%b want 0", cyc, bus.in_rdy); end
         end
         if (bus.out_val === 1'b1) begin
            tests++; if (bus.out_msg !== mk(3, '1)) begin fails++; $display("FAIL sat_msg cyc%0d: got %h want %h", cyc, bus.out_msg, mk(3, '1)); end
         end
         prev_acc = (bus.in_rdy === 1'b1);
         if (prev_acc) sent++;
         tick();
      end
      bus.in_val = 1'b0;
      tests++; if (sent != 300) begin fails++; $display("FAIL sat_budget: got %0d accepts want 300", sent); end
      tick();
      @(negedge clk);
      tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL sat_final: got %0d want 255", err_count); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.ep_resp_msg = {28'hC2, 28'hB1, 28'hA0};
      bus.in_val  = 1'b1;
      bus.in_msg  = mk(3, 28'h0);
      bus.out_rdy = 1'b1;
      tick();
      bus.in_val = 1'b0;
      tick();
      bus.in_val      = 1'b1;
      bus.in_msg      = mk(2, 28'h77);
      bus.ep_resp_val = 3'b010;
      tick();
      bus.in_val      = 1'b0;
      bus.out_rdy     = 1'b0;
      bus.ep_resp_val = '0;
      @(negedge clk);
      tests++; if (bus.ep_req_val !== 3'b100) begin fails++; $display("FAIL rmid_pre_req: got %b want 100", bus.ep_req_val); end
      tests++; if (bus.out_val !== 1'b1 || bus.out_msg !== mk(1, 28'hB1)) begin fails++; $display("FAIL rmid_pre_resp: got val=%b msg=%h want %h", bus.out_val, bus.out_msg, mk(1, 28'hB1)); end
      tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL rmid_pre_err: got %0d want 1", err_count); end
      tick();
      reset           = 1'b1;
      bus.ep_resp_val = 3'b111;
      bus.out_rdy     = 1'b1;
      bus.ep_req_rdy  = 3'b111;
      bus.in_val      = 1'b1;
      bus.in_msg      = mk(0, 28'h5);
      @(negedge clk);
      tests++; if (bus.in_rdy !== 1'b0) begin fails++; $display("FAIL rmid_in_rdy: got %b want 0", bus.in_rdy); end
      tests++; if (bus.ep_resp_rdy !== 3'b000) begin fails++; $display("FAIL rmid_resp_rdy: got %b want 000", bus.ep_resp_rdy); end
      tick();
      reset          = 1'b0;
      bus.in_val     = 1'b0;
      bus.ep_req_rdy = '0;
      @(negedge clk);
      tests++; if (bus.out_val !== 1'b0) begin fails++; $display("FAIL rmid_out_val: got %b want 0", bus.out_val); end
      tests++; if (bus.ep_req_val !== 3'b000) begin fails++; $display("FAIL rmid_req_val: got %b want 000", bus.ep_req_val); end
      tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL rmid_err: got %0d want 0", err_count); end
      tests++; if (bus.ep_resp_rdy !== 3'b001) begin fails++; $display("FAIL rmid_first_grant: got %b want 001", bus.ep_resp_rdy); end
      tick();
      @(negedge clk);
      tests++; if (bus.out_msg !== mk(0, 28'hA0)) begin fails++; $display("FAIL rmid_first_msg: got %h want %h", bus.out_msg, mk(0, 28'hA0)); end
      tests++; if (bus.ep_req_val !== 3'b000) begin fails++; $display("FAIL rmid_no_accept: got %b want 000", bus.ep_req_val); end
      tick();
   endtask

   // Transaction-level model: a pending-request slot, a pending-error flag, a response queue
   // and the index of the next port with round-robin priority.
   task automatic test_random();
      bit             m_req, m_err, slot, exp_in_rdy;
      int             m_port, m_rr, m_errs, exp_g, a, p;
      logic [P-1:0]   m_pay;
      logic [W-1:0]   m_q[$];
      logic [P-1:0]   pays[NP];
      logic [NP-1:0]  exp_rv, exp_gv;
      do_reset();
      m_req = 0; m_err = 0; m_rr = 0; m_errs = 0; m_port = 0; m_pay = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         a = $urandom_range(0, 3);
         bus.in_val      = ($urandom_range(0, 2) != 0);
         bus.in_msg      = {AW'(a), P'($urandom)};
         bus.out_rdy     = ($urandom_range(0, 3) != 0);
         bus.ep_req_rdy  = NP'($urandom);
         bus.ep_resp_val = NP'($urandom);
         for (int i = 0; i < NP; i++) begin
            pays[i] = P'($urandom);
            bus.ep_resp_msg[i*P +: P] = pays[i];
         end
         @(negedge clk);
         exp_in_rdy = !m_req && !m_err;
         exp_rv = m_req ? NP'(1 << m_port) : '0;
         slot = (m_q.size() == 0) || bus.out_rdy;
         exp_g = -1;
         if (slot && !m_err) begin
            for (int k = 0; k < NP; k++) begin
               p = (m_rr + k) % NP;
               if (exp_g < 0 && bus.ep_resp_val[p]) exp_g = p;
            end
         end
         exp_gv = (exp_g >= 0) ? NP'(1 << exp_g) : '0;
         tests++; if (bus.in_rdy !== exp_in_rdy) begin fails++; $display("FAIL rnd_in_rdy cyc%0d: got %b want %b", cyc, bus.in_rdy, exp_in_rdy); end
         tests++; if (bus.ep_req_val !== exp_rv) begin fails++; $display("FAIL rnd_req_val cyc%0d: got %b want %b", cyc, bus.ep_req_val, exp_rv); end
         if (m_req) begin
            tests++; if (bus.ep_req_msg !== m_pay) begin fails++; $display("FAIL rnd_req_msg cyc%0d: got %h want %h", cyc, bus.ep_req_msg, m_pay); end
         end
         tests++; if (bus.out_val !== (m_q.size() != 0)) begin fails++; $display("FAIL rnd_out_val cyc%0d: got %b want %b", cyc, bus.out_val, m_q.size() != 0); end
         if (m_q.size() != 0) begin
            tests++; if (bus.out_msg !== m_q[0]) begin fails++; $display("FAIL rnd_out_msg cyc%0d: got %h want %h", cyc, bus.out_msg, m_q[0]); end
         end
         tests++; if (bus.ep_resp_rdy !== exp_gv) begin fails++; $display("FAIL rnd_grant cyc%0d: got %b want %b", cyc, bus.ep_resp_rdy, exp_gv); end
         tests++; if (err_count !== 8'((m_errs > 255) ? 255 : m_errs)) begin fails++; $display("FAIL rnd_err_count cyc%0d: got %0d want %0d", cyc, err_count, (m_errs > 255) ? 255 : m_errs); end
         if (m_q.size() != 0 && bus.out_rdy) void'(m_q.pop_front());
         if (slot && m_err) begin
            m_q.push_back({AW'(NP), {P{1'b1}}});
            m_err = 0;
         end else if (exp_g >= 0) begin
            m_q.push_back({AW'(exp_g), pays[exp_g]});
            m_rr = (exp_g + 1) % NP;
         end
         if (m_req && bus.ep_req_rdy[m_port]) m_req = 0;
         if (bus.in_val && exp_in_rdy) begin
            if (a < NP) begin
               m_req = 1; m_port = a; m_pay = bus.in_msg[P-1:0];
            end else begin
               m_err = 1; m_errs++;
            end
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_routing();
      test_backpressure();
      test_fairness();
      test_invalid_addr();
      test_err_saturation();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
